semaforo_peatonal: RTL and testbench

- Pedestrian-side controller for the crossing served by the vehicle `semaforo` FSM; it is the other end of the crossing handshake.
- Latches a pedestrian pushbutton press, asserts `cross_req` to the vehicle FSM and waits for `veh_red`.
- Runs a timed WALK / flashing DON'T WALK / clearance sequence, then releases the request.
- Sits beside `semaforo` in the same top level, sharing `clk` and `rst`.

---
 rtl/semaforo_pkg.sv | 38 +++
 rtl/sync_edge.sv | 30 +++
 rtl/semaforo_peatonal.sv | 156 +++++++++++++++
 tb/tb_semaforo_peatonal.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Definitions shared by the vehicle and pedestrian crossing controllers:
// pedestrian state encoding, default crossing timings and steady lamp decode.
package semaforo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RED = 3'd1,
      ST_WALK     = 3'd2,
      ST_FLASH    = 3'd3,
      ST_CLEAR    = 3'd4,
      ST_GAP      = 3'd5
   } ped_state_t;

   // Both ends of the crossing handshake size their phases from these.
   localparam int DEF_T_WALK     = 500;
   localparam int DEF_T_FLASH    = 250;
   localparam int DEF_FLASH_HALF = 25;
   localparam int DEF_T_CLEAR    = 100;
   localparam int DEF_T_GAP      = 100;
   localparam int DEF_CW         = 16;

   typedef struct packed {
      logic cross_req;
      logic walk;
      logic dont_walk;
   } lamps_t;

   // Lamp levels that hold for a whole state; FLASH blinking is layered on top.
   function automatic lamps_t steady_lamps(ped_state_t s);
      lamps_t l;
      l.cross_req = (s == ST_WAIT_RED) || (s == ST_WALK) ||
                    (s == ST_FLASH)    || (s == ST_CLEAR);
      l.walk      = (s == ST_WALK);
      l.dont_walk = (s != ST_WALK);
      return l;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous, active-high input; rise is high for one clk cycle.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_d;

   // NOTE: non-blocking assignments make each stage capture the previous
   // stage's old value; blocking ones would collapse the chain into one flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= din;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rise = sync & ~sync_d;

endmodule

// File: rtl/semaforo_peatonal.sv
// Pedestrian side of the crossing: latches button presses, requests the
// crossing from the vehicle FSM and runs WALK / flashing / clearance / gap.
module semaforo_peatonal
   import semaforo_pkg::*;
#(
   parameter int T_WALK     = DEF_T_WALK,
   parameter int T_FLASH    = DEF_T_FLASH,
   parameter int FLASH_HALF = DEF_FLASH_HALF,
   parameter int T_CLEAR    = DEF_T_CLEAR,
   parameter int T_GAP      = DEF_T_GAP,
   parameter int CW         = DEF_CW
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   input  logic       veh_red,
   output logic       cross_req,
   output logic       walk,
   output logic       dont_walk,
   output logic       pending,
   output logic       err,
   output logic [2:0] state_o
);

   ped_state_t    state;
   ped_state_t    state_nx;
   logic [CW-1:0] timer;
   logic [CW-1:0] timer_nx;
   logic [CW-1:0] flash_cnt;
   logic [CW-1:0] flash_cnt_nx;
   logic          btn_rise;
   logic          entry;
   logic          timer_zero;
   logic          violation;
   logic          pending_nx;
   logic          err_nx;
   logic          dont_walk_nx;
   lamps_t        lamps_nx;

   sync_edge u_btn_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (btn),
      .rise (btn_rise)
   );

   function automatic logic [CW-1:0] load_for(ped_state_t s);
      case (s)
         ST_WALK:  load_for = CW'(T_WALK - 1);
         ST_FLASH: load_for = CW'(T_FLASH - 1);
         ST_CLEAR: load_for = CW'(T_CLEAR - 1);
         ST_GAP:   load_for = CW'(T_GAP - 1);
         default:  load_for = '0;
      endcase
   endfunction

   assign timer_zero = (timer == '0);
   assign entry      = (state_nx != state);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nx  = state;
      violation = 1'b0;
      case (state)
         ST_IDLE: begin
            if (btn_rise || pending) state_nx = ST_WAIT_RED;
         end
         ST_WAIT_RED: begin
            if (veh_red) state_nx = ST_WALK;
         end
         ST_WALK: begin
            if (!veh_red) begin
               violation = 1'b1;
               state_nx  = ST_CLEAR;
            end else if (timer_zero) begin
               state_nx = ST_FLASH;
            end
         end
         ST_FLASH: begin
            if (!veh_red || timer_zero) state_nx = ST_CLEAR;
            violation = !veh_red;
         end
         ST_CLEAR: begin
            violation = !veh_red;
            if (timer_zero) state_nx = ST_GAP;
         end
         ST_GAP: begin
            // A press landing on the exit cycle still counts.
            if (timer_zero) state_nx = (pending || btn_rise) ? ST_WAIT_RED : ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      timer_nx = timer;
      if (entry) begin
         timer_nx = load_for(state_nx);
      end else if (!timer_zero) begin
         timer_nx = timer - 1'b1;
      end
   end

   always_comb begin
      lamps_nx     = steady_lamps(state_nx);
      dont_walk_nx = lamps_nx.dont_walk;
      flash_cnt_nx = '0;
      if (state_nx == ST_FLASH) begin
         if (entry || flash_cnt == '0) begin
            flash_cnt_nx = CW'(FLASH_HALF - 1);
         end else begin
            flash_cnt_nx = flash_cnt - 1'b1;
         end
         // Flash opens lit and toggles each time a half-period runs out.
         if (!entry) begin
            dont_walk_nx = (flash_cnt == '0) ? ~dont_walk : dont_walk;
         end
      end
   end

   always_comb begin
      pending_nx = pending;
      if (entry && state_nx == ST_WALK) begin
         pending_nx = 1'b0;
      end else if (btn_rise && state != ST_WALK && state != ST_FLASH) begin
         pending_nx = 1'b1;
      end
      err_nx = err | violation;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         flash_cnt <= '0;
         pending   <= 1'b0;
         err       <= 1'b0;
         cross_req <= 1'b0;
         walk      <= 1'b0;
         dont_walk <= 1'b1;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         flash_cnt <= flash_cnt_nx;
         pending   <= pending_nx;
         err       <= err_nx;
         cross_req <= lamps_nx.cross_req;
         walk      <= lamps_nx.walk;
         dont_walk <= dont_walk_nx;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_semaforo_peatonal.sv
// Self-checking bench for semaforo_peatonal: directed vectors, corner-case
// sequences and random traffic compared against a behavioural crossing model.
module tb_semaforo_peatonal;

   localparam int T_WALK     = 8;
   localparam int T_FLASH    = 6;
   localparam int FLASH_HALF = 2;
   localparam int T_CLEAR    = 3;
   localparam int T_GAP      = 5;

   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_WALK  = 2;
   localparam int P_FLASH = 3;
   localparam int P_CLEAR = 4;
   localparam int P_GAP   = 5;

   // {cross_req, walk, dont_walk, pending, err, state[2:0]}
   localparam logic [7:0] RST_OUTS = 8'b0010_0000;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       btn     = 1'b0;
   logic       veh_red = 1'b0;
   logic       cross_req;
   logic       walk;
   logic       dont_walk;
   logic       pending;
   logic       err;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_pass   = 0;

   semaforo_peatonal #(
      .T_WALK     (T_WALK),
      .T_FLASH    (T_FLASH),
      .FLASH_HALF (FLASH_HALF),
      .T_CLEAR    (T_CLEAR),
      .T_GAP      (T_GAP),
      .CW         (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .veh_red   (veh_red),
      .cross_req (cross_req),
      .walk      (walk),
      .dont_walk (dont_walk),
      .pending   (pending),
      .err       (err),
      .state_o   (state_o)
   );

   always #10 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   typedef struct {
      int       phase;
      int       elapsed;   // cycles already spent in the phase
      bit       pending;
      bit       err;
      bit [2:0] hist;      // btn as sampled on the last three edges, newest in [0]
   } model_t;

   model_t m;

   function automatic int phase_len(int p);
      case (p)
         P_WALK:  return T_WALK;
         P_FLASH: return T_FLASH;
         P_CLEAR: return T_CLEAR;
         P_GAP:   return T_GAP;
         default: return 1;
      endcase
   endfunction

   function automatic model_t model_next(model_t cur, bit b, bit v);
      model_t n;
      bit     rise;
      bit     done;
      int     nxt;
      n    = cur;
      rise = cur.hist[1] && !cur.hist[2];
      done = (cur.elapsed + 1 >= phase_len(cur.phase));
      nxt  = cur.phase;
      case (cur.phase)
         P_IDLE:  if (rise || cur.pending) nxt = P_WAIT;
         P_WAIT:  if (v) nxt = P_WALK;
         P_WALK, P_FLASH: begin
            if (!v) begin
               n.err = 1'b1;
               nxt   = P_CLEAR;
            end else if (done) begin
               nxt = cur.phase + 1;
            end
         end
         P_CLEAR: begin
            if (!v) n.err = 1'b1;
            if (done) nxt = P_GAP;
         end
         P_GAP:   if (done) nxt = (cur.pending || rise) ? P_WAIT : P_IDLE;
         default: nxt = P_IDLE;
      endcase
      if (nxt == P_WALK && cur.phase != P_WALK) n.pending = 1'b0;
      else if (rise && cur.phase != P_WALK && cur.phase != P_FLASH) n.pending = 1'b1;
      n.elapsed = (nxt == cur.phase) ? cur.elapsed + 1 : 0;
      n.phase   = nxt;
      n.hist    = {cur.hist[1:0], b};
      return n;
   endfunction

   function automatic logic [7:0] model_outs(model_t cur);
      logic cr;
      logic dw;
      cr = cur.phase inside {[P_WAIT:P_CLEAR]};
      if (cur.phase == P_WALK)       dw = 1'b0;
      else if (cur.phase == P_FLASH) dw = ((cur.elapsed / FLASH_HALF) % 2) == 0;
      else                           dw = 1'b1;
      return {cr, cur.phase == P_WALK, dw, cur.pending, cur.err, 3'(cur.phase)};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '{phase: P_IDLE, elapsed: 0, pending: 1'b0, err: 1'b0, hist: 3'b000};
      else     m <= model_next(m, btn, veh_red);
   end

   // ---------------- helpers ----------------
   function automatic logic [7:0] outs();
      return {cross_req, walk, dont_walk, pending, err, state_o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #15;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic press();
      btn = 1'b1;
      tick();
      btn = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, input string name);
      int n = 0;
      while (state_o !== target && n < budget) begin
         tick();
         n++;
      end
      check(name, state_o, target);
   endtask

   typedef struct {
      logic       btn;
      logic       veh;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic b, input logic v, input logic cr, input logic w,
                      input logic dw, input logic p, input logic e, input logic [2:0] st);
      vec_t r;
      r.btn = b;
      r.veh = v;
      r.exp = {cr, w, dw, p, e, st};
      vecs.push_back(r);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Nominal crossing: inputs per cycle and the outputs after that edge.
      add(1, 0, 0, 0, 1, 0, 0, 3'd0);
      add(0, 0, 0, 0, 1, 0, 0, 3'd0);
      add(0, 0, 1, 0, 1, 1, 0, 3'd1);
      for (int i = 0; i < 8; i++) add(0, 1, 1, 1, 0, 0, 0, 3'd2);
      add(0, 1, 1, 0, 1, 0, 0, 3'd3);
      add(0, 1, 1, 0, 1, 0, 0, 3'd3);
      add(0, 1, 1, 0, 0, 0, 0, 3'd3);
      add(0, 1, 1, 0, 0, 0, 0, 3'd3);
      add(0, 1, 1, 0, 1, 0, 0, 3'd3);
      add(0, 1, 1, 0, 1, 0, 0, 3'd3);
      for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 1, 0, 0, 3'd4);
      add(0, 1, 0, 0, 1, 0, 0, 3'd5);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 0, 3'd5);
      add(0, 0, 0, 0, 1, 0, 0, 3'd0);
      add(0, 0, 0, 0, 1, 0, 0, 3'd0);

      // Reset state and quiet idling.
      do_reset();
      check("reset", outs(), RST_OUTS);
      for (int i = 0; i < 50; i++) begin
         tick();
         check("idle_hold", outs(), RST_OUTS);
      end

      // Nominal crossing from the table.
      for (int i = 0; i < vecs.size(); i++) begin
         btn     = vecs[i].btn;
         veh_red = vecs[i].veh;
         tick();
         check($sformatf("nominal[%0d]", i), outs(), vecs[i].exp);
      end

      // Delayed grant: request stays open while veh_red is low.
      press();
      check("delay_req", state_o, 3'd1);
      for (int i = 0; i < 40; i++) begin
         tick();
         check("delay_hold", {walk, state_o}, {1'b0, 3'd1});
      end
      veh_red = 1'b1;
      tick();
      check("delay_walk", {walk, state_o}, {1'b1, 3'd2});
      wait_state(3'd5, 40, "delay_gap");
      veh_red = 1'b0;
      wait_state(3'd0, 20, "delay_idle");

      // Press during GAP queues the next crossing.
      press();
      veh_red = 1'b1;
      tick();
      wait_state(3'd5, 40, "gap_enter");
      veh_red = 1'b0;
      btn     = 1'b1;
      tick();
      btn = 1'b0;
      tick();
      tick();
      check("gap_pending", {pending, state_o}, {1'b1, 3'd5});
      tick();
      check("gap_last", state_o, 3'd5);
      tick();
      check("gap_requeue", {cross_req, pending, state_o}, {1'b1, 1'b1, 3'd1});
      veh_red = 1'b1;
      tick();
      check("gap_walk_clr", {pending, walk, state_o}, {1'b0, 1'b1, 3'd2});

      // Violation: vehicle lamp leaves red mid-WALK.
      tick();
      tick();
      tick();
      veh_red = 1'b0;
      tick();
      check("viol_clear", outs(), 8'b1010_1100);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("viol_clear_hold", outs(), 8'b1010_1100);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         check("viol_gap", outs(), 8'b0010_1101);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         check("viol_idle", outs(), 8'b0010_1000);
      end
      do_reset();
      check("viol_reset", outs(), RST_OUTS);

      // Asynchronous reset in the middle of FLASH.
      press();
      veh_red = 1'b1;
      tick();
      wait_state(3'd3, 20, "async_flash");
      #3;
      rst = 1'b1;
      #1;
      check("async_now", outs(), RST_OUTS);
      #11;
      rst     = 1'b0;
      veh_red = 1'b0;
      @(negedge clk);
      check("async_after", outs(), RST_OUTS);

      // Random traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         check("random", outs(), model_outs(m));
         if ($urandom_range(0, 39) == 0) btn = ~btn;
         r = $urandom_range(0, 999);
         if (cross_req) begin
            if (!veh_red && r < 300)     veh_red = 1'b1;
            else if (veh_red && r < 4)   veh_red = 1'b0;
         end else if (veh_red && r < 200) begin
            veh_red = 1'b0;
         end
         if (i % 700 == 699) do_reset();
         else tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
